// File: rtl/exe_issue_ctrl.sv
// rtl/exe_issue_ctrl.sv - issue gating between decode and exe_stage
// RAW scoreboard, in-flight limit and one-cycle flush/redirect after a taken jump.
module exe_issue_ctrl #(
   parameter int DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_id_req,
   output logic        o_id_ack,
   input  logic [4:0]  i_id_rs1,
   input  logic [4:0]  i_id_rs2,
   input  logic        i_id_rs1_ren,
   input  logic        i_id_rs2_ren,
   input  logic [4:0]  i_id_rd,
   input  logic        i_id_rd_wen,
   output logic        o_ex_decoded_req,
   input  logic        i_ex_executed_req,
   input  logic        i_ex_pc_jmp,
   input  logic [63:0] i_ex_pc_jmpaddr,
   input  logic        i_wb_retire,
   output logic        o_redirect,
   output logic [63:0] o_redirect_pc,
   output logic        o_busy,
   output logic [31:0] o_stall_cnt
);

   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;
   localparam logic [2:0] LAST    = 3'(DEPTH - 1);
   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   logic [0:0]  state_q;
   logic [7:0]  occ_q;
   logic [7:0]  wr_q;
   logic [4:0]  rd_q [8];
   logic [2:0]  head_q;
   logic [2:0]  tail_q;
   logic [2:0]  count_q;
   logic [63:0] pc_q;
   logic [31:0] stall_cnt_q;

   logic hazard;
   logic jmp_now;
   logic run;
   logic issue;
   logic retire;

   function automatic logic [2:0] nxt(input logic [2:0] p);
      return (p == LAST) ? 3'd0 : p + 3'd1;
   endfunction

   // Slots are tagged occupied, so the head entry retiring this cycle still blocks.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (occ_q[i] && wr_q[i] &&
             ((i_id_rs1_ren && i_id_rs1 != 5'd0 && i_id_rs1 == rd_q[i]) ||
              (i_id_rs2_ren && i_id_rs2 != 5'd0 && i_id_rs2 == rd_q[i])))
            hazard = 1'b1;
      end
      hazard = hazard & i_id_req;
   end

   assign jmp_now = i_ex_executed_req & i_ex_pc_jmp;
   assign run     = (state_q == S_RUN);
   assign issue   = !rst && run && i_id_req && !hazard && (count_q < DEPTH_C) && !jmp_now;
   assign retire  = i_wb_retire && (count_q != 3'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         occ_q       <= '0;
         wr_q        <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         pc_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (run && jmp_now) begin
            state_q <= S_FLUSH;
            pc_q    <= i_ex_pc_jmpaddr;
         end else if (!run) begin
            state_q <= S_RUN;
         end
         if (run && hazard && !jmp_now)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (retire) begin
            occ_q[head_q] <= 1'b0;
            head_q        <= nxt(head_q);
         end
         if (issue) begin
            occ_q[tail_q] <= 1'b1;
            wr_q[tail_q]  <= i_id_rd_wen && (i_id_rd != 5'd0);
            tail_q        <= nxt(tail_q);
         end
         case ({issue, retire})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (issue)
         rd_q[tail_q] <= i_id_rd;
   end

   assign o_id_ack         = issue;
   assign o_ex_decoded_req = issue;
   assign o_redirect       = (state_q == S_FLUSH);
   assign o_redirect_pc    = pc_q;
   assign o_busy           = (count_q != 3'd0);
   assign o_stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// tb/tb_exe_issue_ctrl.sv - self-checking bench for exe_issue_ctrl
// Queue-based reference model checked every cycle plus directed literal checks.
module tb_exe_issue_ctrl;

   localparam int DEPTH = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_id_req;
   logic        o_id_ack;
   logic [4:0]  i_id_rs1;
   logic [4:0]  i_id_rs2;
   logic        i_id_rs1_ren;
   logic        i_id_rs2_ren;
   logic [4:0]  i_id_rd;
   logic        i_id_rd_wen;
   logic        o_ex_decoded_req;
   logic        i_ex_executed_req;
   logic        i_ex_pc_jmp;
   logic [63:0] i_ex_pc_jmpaddr;
   logic        i_wb_retire;
   logic        o_redirect;
   logic [63:0] o_redirect_pc;
   logic        o_busy;
   logic [31:0] o_stall_cnt;

   exe_issue_ctrl #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_id_req          (i_id_req),
      .o_id_ack          (o_id_ack),
      .i_id_rs1          (i_id_rs1),
      .i_id_rs2          (i_id_rs2),
      .i_id_rs1_ren      (i_id_rs1_ren),
      .i_id_rs2_ren      (i_id_rs2_ren),
      .i_id_rd           (i_id_rd),
      .i_id_rd_wen       (i_id_rd_wen),
      .o_ex_decoded_req  (o_ex_decoded_req),
      .i_ex_executed_req (i_ex_executed_req),
      .i_ex_pc_jmp       (i_ex_pc_jmp),
      .i_ex_pc_jmpaddr   (i_ex_pc_jmpaddr),
      .i_wb_retire       (i_wb_retire),
      .o_redirect        (o_redirect),
      .o_redirect_pc     (o_redirect_pc),
      .o_busy            (o_busy),
      .o_stall_cnt       (o_stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: in-flight list of {writes, rd}, oldest first.
   logic [5:0]  mq[$];
   bit          m_flush = 1'b0;
   logic [63:0] m_pc    = '0;
   logic [31:0] m_stall = '0;
   bit          mdl_on  = 1'b0;

   function automatic bit m_haz();
      foreach (mq[i]) begin
         if (mq[i][5] && ((i_id_rs1_ren && i_id_rs1 != 0 && i_id_rs1 == mq[i][4:0]) ||
                          (i_id_rs2_ren && i_id_rs2 != 0 && i_id_rs2 == mq[i][4:0])))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (mdl_on) begin
         bit jmp, haz, ack;
         jmp = i_ex_executed_req && i_ex_pc_jmp;
         haz = i_id_req && m_haz();
         ack = !rst && !m_flush && i_id_req && !haz && (mq.size() < DEPTH) && !jmp;
         chk("m_ack", 64'(o_id_ack), 64'(ack));
         chk("m_decoded_req", 64'(o_ex_decoded_req), 64'(ack));
         chk("m_redirect", 64'(o_redirect), 64'(m_flush));
         chk("m_redirect_pc", o_redirect_pc, m_pc);
         chk("m_busy", 64'(o_busy), 64'(mq.size() != 0));
         chk("m_stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
         if (rst) begin
            mq.delete();
            m_flush = 1'b0;
            m_pc    = '0;
            m_stall = '0;
         end else begin
            if (m_flush) begin
               m_flush = 1'b0;
            end else begin
               if (jmp) begin
                  m_flush = 1'b1;
                  m_pc    = i_ex_pc_jmpaddr;
               end else if (haz) begin
                  m_stall = m_stall + 1;
               end
            end
            if (i_wb_retire && mq.size() != 0)
               void'(mq.pop_front());
            if (ack)
               mq.push_back({i_id_rd_wen && i_id_rd != 0, i_id_rd});
         end
      end
   end

   task automatic idle();
      i_id_req = 0; i_id_rs1 = 0; i_id_rs1_ren = 0; i_id_rs2 = 0; i_id_rs2_ren = 0;
      i_id_rd = 0; i_id_rd_wen = 0; i_ex_executed_req = 0; i_ex_pc_jmp = 0;
      i_ex_pc_jmpaddr = 0; i_wb_retire = 0;
   endtask

   task automatic instr(input logic [4:0] s1, input logic e1, input logic [4:0] s2,
                        input logic e2, input logic [4:0] d, input logic we);
      i_id_req = 1; i_id_rs1 = s1; i_id_rs1_ren = e1; i_id_rs2 = s2; i_id_rs2_ren = e2;
      i_id_rd = d; i_id_rd_wen = we;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1;
      instr(0, 0, 0, 0, 5'd1, 1);
      tick();
      mdl_on = 1;
      @(negedge clk);
      chk("rst_ack", 64'(o_id_ack), 64'd0);
      chk("rst_redirect", 64'(o_redirect), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_pc", o_redirect_pc, 64'd0);
      chk("rst_stall", 64'(o_stall_cnt), 64'd0);
      tick();
      rst = 0;
      @(negedge clk); chk("first_ack", 64'(o_id_ack), 64'd1); tick();
      instr(0, 0, 0, 0, 5'd2, 1);
      @(negedge clk); chk("b2b_ack1", 64'(o_id_ack), 64'd1); tick();
      instr(0, 0, 0, 0, 5'd3, 1);
      @(negedge clk); chk("b2b_ack2", 64'(o_id_ack), 64'd1); tick();
      instr(0, 0, 0, 0, 5'd4, 1);
      @(negedge clk); chk("full_noack", 64'(o_id_ack), 64'd0); chk("full_busy", 64'(o_busy), 64'd1); tick();
      i_wb_retire = 1;
      @(negedge clk); chk("full_retire_noack", 64'(o_id_ack), 64'd0); tick();
      i_wb_retire = 0;
      @(negedge clk); chk("after_retire_ack", 64'(o_id_ack), 64'd1); tick();
      idle();
      i_wb_retire = 1;
      repeat (3) tick();
      i_wb_retire = 0;
      @(negedge clk); chk("drain_busy", 64'(o_busy), 64'd0);
      tick();

      // RAW stall on x5
      instr(0, 0, 0, 0, 5'd5, 1);
      @(negedge clk); chk("prod_ack", 64'(o_id_ack), 64'd1); tick();
      instr(5'd5, 1, 0, 0, 5'd6, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("raw_noack", 64'(o_id_ack), 64'd0);
         chk("raw_stall", 64'(o_stall_cnt), 64'(k));
         tick();
      end
      i_wb_retire = 1;
      @(negedge clk); chk("raw_retire_noack", 64'(o_id_ack), 64'd0); chk("raw_stall3", 64'(o_stall_cnt), 64'd3); tick();
      i_wb_retire = 0;
      @(negedge clk); chk("raw_release_ack", 64'(o_id_ack), 64'd1); chk("raw_stall4", 64'(o_stall_cnt), 64'd4); tick();

      // x0 never hazards
      instr(0, 0, 0, 0, 5'd0, 1);
      @(negedge clk); chk("x0_prod_ack", 64'(o_id_ack), 64'd1); tick();
      instr(5'd0, 1, 0, 0, 5'd7, 1);
      @(negedge clk); chk("x0_cons_ack", 64'(o_id_ack), 64'd1); chk("x0_stall", 64'(o_stall_cnt), 64'd4); tick();
      idle();
      i_wb_retire = 1;
      tick();

      // simultaneous issue + retire at count 2
      instr(5'd1, 1, 0, 0, 5'd8, 1);
      @(negedge clk); chk("sim_ack", 64'(o_id_ack), 64'd1); tick();
      instr(5'd7, 1, 0, 0, 5'd9, 1);
      @(negedge clk); chk("retiring_rd_noack", 64'(o_id_ack), 64'd0); tick();
      i_wb_retire = 0;
      @(negedge clk); chk("retired_rd_ack", 64'(o_id_ack), 64'd1); tick();
      idle();
      i_wb_retire = 1;
      tick();
      @(negedge clk); chk("count_one_busy", 64'(o_busy), 64'd1); tick();
      i_wb_retire = 0;
      @(negedge clk); chk("count_zero_busy", 64'(o_busy), 64'd0); tick();

      // jump flush, with a second jump during FLUSH ignored
      instr(0, 0, 0, 0, 5'd11, 1);
      i_ex_executed_req = 1; i_ex_pc_jmp = 1; i_ex_pc_jmpaddr = 64'h8000_0100;
      @(negedge clk); chk("jmp_noack", 64'(o_id_ack), 64'd0); tick();
      i_ex_pc_jmpaddr = 64'hDEAD_BEEF;
      @(negedge clk);
      chk("flush_redirect", 64'(o_redirect), 64'd1);
      chk("flush_pc", o_redirect_pc, 64'h8000_0100);
      chk("flush_noack", 64'(o_id_ack), 64'd0);
      tick();
      i_ex_executed_req = 0; i_ex_pc_jmp = 0;
      @(negedge clk);
      chk("resume_redirect", 64'(o_redirect), 64'd0);
      chk("resume_ack", 64'(o_id_ack), 64'd1);
      chk("pc_hold", o_redirect_pc, 64'h8000_0100);
      tick();

      // reset during FLUSH
      idle();
      i_ex_executed_req = 1; i_ex_pc_jmp = 1; i_ex_pc_jmpaddr = 64'h1234;
      tick();
      idle();
      rst = 1;
      @(negedge clk); chk("rstflush_pre", 64'(o_redirect), 64'd1); tick();
      rst = 0;
      @(negedge clk);
      chk("rstflush_redirect", 64'(o_redirect), 64'd0);
      chk("rstflush_busy", 64'(o_busy), 64'd0);
      chk("rstflush_pc", o_redirect_pc, 64'd0);
      tick();

      // stall counter wrap
      instr(0, 0, 0, 0, 5'd10, 1);
      @(negedge clk); chk("wrap_prod_ack", 64'(o_id_ack), 64'd1); tick();
      instr(0, 0, 5'd10, 1, 5'd12, 1);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      m_stall = 32'hFFFF_FFFF;
      #2;
      release dut.stall_cnt_q;
      @(negedge clk); chk("wrap_pre", 64'(o_stall_cnt), 64'hFFFF_FFFF); tick();
      @(negedge clk); chk("wrap_zero", 64'(o_stall_cnt), 64'd0); chk("wrap_noack", 64'(o_id_ack), 64'd0); tick();
      idle();
      i_wb_retire = 1;
      tick();
      i_wb_retire = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
